// File: rtl/median_filter_tx_mc_pkg.sv
// Shared types and default geometry for the median filter output stage.
package median_filter_pkg;
    localparam int DW_VD_DEF   = 14;
    localparam int DW_VX_DEF   = 4;
    localparam int NCH_DEF     = 1;
    localparam int BUF_LEN_DEF = 2048;
    localparam int EOL_BIT_DEF = 1;
    localparam int DW_FIFO     = NCH_DEF * DW_VD_DEF + DW_VX_DEF;
    localparam int AW          = $clog2(BUF_LEN_DEF);

    typedef enum logic {IDLE_LINE, IN_LINE} state_t;
endpackage

// File: rtl/median_filter_tx_mc_if.sv
// Video beat bus: packed channel data plus aux, valid/ready handshake.
interface median_filter_tx_mc_if #(
    parameter int DW_VD = 14,
    parameter int DW_VX = 4,
    parameter int NCH   = 1
);
    logic                   val;
    logic                   rdy;
    logic [DW_VX-1:0]       aux;
    logic [NCH*DW_VD-1:0]   dat;

    modport master (output val, aux, dat, input rdy);
    modport slave  (input val, aux, dat, output rdy);
endinterface

// File: rtl/median_filter_tx_mc_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module mf_tx_fifo
    import median_filter_pkg::*;
#(
    parameter int W     = DW_FIFO,
    parameter int DEPTH = 1 << AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          wr_ok, rd_ok;

    assign empty = (level == '0);
    assign full  = (level == (PW+1)'(DEPTH));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (wr_ok) wp <= wp + PW'(1);
            if (rd_ok) rp <= rp + PW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + (PW+1)'(1);
                2'b01:   level <= level - (PW+1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/median_filter_tx_mc.sv
// Multi-channel video output stage: line-reserving admission into a FIFO,
// handshaked master output, line tracking, flush and sticky error flags.
module median_filter_tx_mc
    import median_filter_pkg::*;
#(
    parameter int DW_VD   = DW_VD_DEF,
    parameter int DW_VX   = DW_VX_DEF,
    parameter int NCH     = NCH_DEF,
    parameter int BUF_LEN = BUF_LEN_DEF,
    parameter int EOL_BIT = EOL_BIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    median_filter_tx_mc_if.slave         s_vb,
    median_filter_tx_mc_if.master        m_vb,
    input  logic [15:0]                  iw,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic                         uflow,
    output logic                         oflow,
    output logic                         iw_err,
    output logic [$clog2(BUF_LEN):0]     lines,
    output logic [$clog2(BUF_LEN):0]     level
);
    localparam int FW = NCH * DW_VD + DW_VX;
    localparam int LW = $clog2(BUF_LEN) + 1;

    state_t        state, state_nx;
    logic [15:0]   iw_lat, bcnt;
    logic [FW-1:0] dout;
    logic          empty, full, wr, rd, iw_ok, space_ok, eol_in, eol_out;
    logic          uflow_set, oflow_set, iw_err_set, lines_dec;

    mf_tx_fifo #(.W(FW), .DEPTH(BUF_LEN)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr),
        .rd_en (rd),
        .din   ({s_vb.aux, s_vb.dat}),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    assign m_vb.aux = dout[FW-1 -: DW_VX];
    assign m_vb.dat = dout[NCH*DW_VD-1:0];
    assign m_vb.val = !rst && !empty && !flush;

    // A line is only admitted when the whole of it fits, so IN_LINE never stalls on space.
    assign iw_ok    = (iw != 16'd0) && (int'(iw) <= BUF_LEN);
    assign space_ok = (BUF_LEN - int'(level)) >= int'(iw);
    assign s_vb.rdy = !rst && !flush && ((state == IDLE_LINE) ? (iw_ok && space_ok) : !full);

    assign wr      = s_vb.val && s_vb.rdy;
    assign rd      = flush ? !empty : (m_vb.val && m_vb.rdy);
    assign eol_in  = s_vb.aux[EOL_BIT];
    assign eol_out = m_vb.aux[EOL_BIT];

    assign uflow_set  = (state == IN_LINE) && empty && m_vb.rdy;
    assign oflow_set  = s_vb.val && full;
    assign iw_err_set = (state == IDLE_LINE) && !iw_ok;
    assign lines_dec  = rd && eol_out && (lines != '0);

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE_LINE;
        end else if (wr) begin
            if (state == IDLE_LINE) begin
                if (!eol_in && iw != 16'd1) state_nx = IN_LINE;
            end else if (eol_in || (bcnt + 16'd1) == iw_lat) begin
                state_nx = IDLE_LINE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE_LINE;
            iw_lat <= '0;
            bcnt   <= '0;
            lines  <= '0;
            uflow  <= 1'b0;
            oflow  <= 1'b0;
            iw_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (wr) begin
                if (state == IDLE_LINE) begin
                    iw_lat <= iw;
                    bcnt   <= 16'd1;
                end else begin
                    bcnt   <= bcnt + 16'd1;
                end
            end
            case ({wr && eol_in, lines_dec})
                2'b10:   lines <= lines + LW'(1);
                2'b01:   lines <= lines - LW'(1);
                default: lines <= lines;
            endcase
            // Set wins over clear; flags are frozen while flushing.
            if (!flush) begin
                uflow  <= uflow_set  || (uflow  && !err_clr);
                oflow  <= oflow_set  || (oflow  && !err_clr);
                iw_err <= iw_err_set || (iw_err && !err_clr);
            end
        end
    end
endmodule

// File: tb/tb_median_filter_tx_mc.sv
// Randomized and directed check of median_filter_tx_mc against a queue-based model.
module tb_median_filter_tx_mc;
    import median_filter_pkg::*;

    localparam int DW_VD   = 14;
    localparam int DW_VX   = 4;
    localparam int NCH     = 2;
    localparam int BUF_LEN = 16;
    localparam int EOL_BIT = 1;
    localparam int LW      = $clog2(BUF_LEN) + 1;
    localparam int DW      = NCH * DW_VD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   iw;
    logic          flush, err_clr;
    logic          uflow, oflow, iw_err;
    logic [LW-1:0] lines, level;

    median_filter_tx_mc_if #(.DW_VD(DW_VD), .DW_VX(DW_VX), .NCH(NCH)) s_vb ();
    median_filter_tx_mc_if #(.DW_VD(DW_VD), .DW_VX(DW_VX), .NCH(NCH)) m_vb ();

    median_filter_tx_mc #(
        .DW_VD(DW_VD), .DW_VX(DW_VX), .NCH(NCH), .BUF_LEN(BUF_LEN), .EOL_BIT(EOL_BIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_vb    (s_vb),
        .m_vb    (m_vb),
        .iw      (iw),
        .flush   (flush),
        .err_clr (err_clr),
        .uflow   (uflow),
        .oflow   (oflow),
        .iw_err  (iw_err),
        .lines   (lines),
        .level   (level)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the buffer is a queue of {aux,dat}; rem = beats still owed to the open line.
    logic [31:0] q[$];
    int          rem = 0;
    bit          m_uf, m_of, m_ie;
    bit          m_w, m_rd, m_mv, m_e;

    function automatic bit model_rdy();
        if (flush) return 1'b0;
        if (rem > 0) return q.size() < BUF_LEN;
        return (iw != 0) && (int'(iw) <= BUF_LEN) && ((BUF_LEN - q.size()) >= int'(iw));
    endfunction

    function automatic int model_lines();
        int n = 0;
        foreach (q[i]) if (q[i][DW + EOL_BIT]) n++;
        return n;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            rem  = 0;
            m_uf = 0;
            m_of = 0;
            m_ie = 0;
        end else begin
            m_w  = s_vb.val && model_rdy();
            m_mv = (q.size() > 0) && !flush;
            m_rd = flush ? (q.size() > 0) : (m_mv && m_vb.rdy);
            if (!flush) begin
                m_uf = (rem > 0 && q.size() == 0 && m_vb.rdy) || (m_uf && !err_clr);
                m_of = (s_vb.val && q.size() == BUF_LEN) || (m_of && !err_clr);
                m_ie = (rem == 0 && !(iw != 0 && int'(iw) <= BUF_LEN)) || (m_ie && !err_clr);
            end
            if (m_rd) void'(q.pop_front());
            if (m_w) begin
                q.push_back({s_vb.aux, s_vb.dat});
                m_e = s_vb.aux[EOL_BIT];
                if (rem == 0) rem = m_e ? 0 : int'(iw) - 1;
                else          rem = m_e ? 0 : rem - 1;
            end
            if (flush) rem = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy", s_vb.rdy, model_rdy());
            chk("m_val", m_vb.val, (q.size() > 0) && !flush);
            if ((q.size() > 0) && !flush) chk("m_data", {m_vb.aux, m_vb.dat}, q[0]);
            chk("level", level, q.size());
            chk("lines", lines, model_lines());
            chk("uflow", uflow, m_uf);
            chk("oflow", oflow, m_of);
            chk("iw_err", iw_err, m_ie);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [DW_VX-1:0] a, input logic [DW-1:0] d);
        s_vb.val = v;
        s_vb.aux = a;
        s_vb.dat = d;
    endtask

    localparam logic [DW_VX-1:0] EOL = DW_VX'(1) << EOL_BIT;

    initial begin
        logic [15:0] iw_tab [8];
        int          rdy_pct;
        iw_tab = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd16, 16'd17};

        iw = 16'd4; flush = 0; err_clr = 0; m_vb.rdy = 0;
        drv(0, '0, '0);
        repeat (3) step();
        rst = 0;
        @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_lines", lines, 0);
        chk("rst_flags", {uflow, oflow, iw_err}, 0);

        // one line streamed straight through
        m_vb.rdy = 1;
        for (int i = 0; i < 4; i++) begin
            drv(1, (i == 3) ? EOL : '0, DW'(28'h1000 + i));
            step();
        end
        drv(0, '0, '0);
        @(negedge clk);
        chk("l1_level", level, 1);
        chk("l1_lines", lines, 1);
        chk("l1_dat", m_vb.dat, 32'h1003);
        step();
        @(negedge clk);
        chk("l1_drained_lines", lines, 0);

        // reservation blocks a third 6-beat line
        iw = 16'd6; m_vb.rdy = 0;
        for (int i = 0; i < 14; i++) begin
            drv(1, (i % 6 == 5) ? EOL : '0, DW'($urandom));
            step();
        end
        drv(0, '0, '0);
        @(negedge clk);
        chk("res_level", level, 12);
        chk("res_lines", lines, 2);
        chk("res_rdy", s_vb.rdy, 0);
        m_vb.rdy = 1;
        step(); step();
        m_vb.rdy = 0;
        @(negedge clk);
        chk("res_level2", level, 10);
        chk("res_rdy2", s_vb.rdy, 1);
        m_vb.rdy = 1;
        repeat (12) step();

        // EOL in and EOL out on the same edge
        iw = 16'd2; m_vb.rdy = 0;
        drv(1, '0, DW'(28'hA)); step();
        drv(1, EOL, DW'(28'hB)); step();
        m_vb.rdy = 1;
        drv(1, '0, DW'(28'hC)); step();
        drv(1, EOL, DW'(28'hD)); step();
        drv(0, '0, '0); m_vb.rdy = 0;
        @(negedge clk);
        chk("same_lines", lines, 1);
        chk("same_level", level, 2);
        m_vb.rdy = 1;
        repeat (3) step();

        // bad width and err_clr priority
        m_vb.rdy = 0; iw = 16'd0;
        @(negedge clk);
        chk("iw0_rdy", s_vb.rdy, 0);
        step();
        @(negedge clk);
        chk("iw0_err", iw_err, 1);
        err_clr = 1; step();
        @(negedge clk);
        chk("iw0_err_held", iw_err, 1);
        iw = 16'd8; err_clr = 0; step();
        err_clr = 1; step();
        err_clr = 0;
        @(negedge clk);
        chk("iw_err_cleared", iw_err, 0);
        chk("iw8_rdy", s_vb.rdy, 1);

        // flush of 10 buffered beats
        iw = 16'd5;
        for (int i = 0; i < 10; i++) begin
            drv(1, (i == 4 || i == 9) ? EOL : '0, DW'($urandom));
            step();
        end
        drv(0, '0, '0);
        @(negedge clk);
        chk("fl_level0", level, 10);
        chk("fl_lines0", lines, 2);
        flush = 1;
        repeat (10) step();
        @(negedge clk);
        chk("fl_level", level, 0);
        chk("fl_lines", lines, 0);
        chk("fl_mval", m_vb.val, 0);
        flush = 0;
        #1;
        chk("fl_rdy", s_vb.rdy, 1);

        // overflow when full, underflow mid-line
        iw = 16'd16;
        for (int i = 0; i < 16; i++) begin
            drv(1, '0, DW'($urandom));
            step();
        end
        step();
        @(negedge clk);
        chk("of_flag", oflow, 1);
        chk("of_level", level, 16);
        drv(0, '0, '0); m_vb.rdy = 1; iw = 16'd8;
        repeat (16) step();
        drv(1, '0, DW'(28'h55)); step();
        drv(0, '0, '0); step(); step();
        @(negedge clk);
        chk("uf_flag", uflow, 1);
        m_vb.rdy = 0; err_clr = 1; step(); err_clr = 0;
        @(negedge clk);
        chk("clr_flags", {uflow, oflow, iw_err}, 0);

        // random traffic
        rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) rdy_pct = $urandom_range(10, 100);
            if ($urandom_range(0, 49) == 0) iw = iw_tab[$urandom_range(0, 7)];
            flush    = ($urandom_range(0, 99) < 3);
            err_clr  = ($urandom_range(0, 19) == 0);
            m_vb.rdy = ($urandom_range(1, 100) <= rdy_pct);
            drv($urandom_range(0, 3) != 0,
                DW_VX'($urandom) & ~EOL | (($urandom_range(0, 5) == 0) ? EOL : '0),
                DW'($urandom));
            rst = (i >= 1500 && i < 1502);
            step();
        end
        rst = 0; drv(0, '0, '0); flush = 0;
        step();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
